cache_2way: RTL and testbench
=============================

# cache_2way

Write-back, write-allocate data/instruction cache that sits directly below the pipeline's 30-bit word-addressed cache port and above the 128-bit slow memory. It serves hits combinationally with no stall, and stalls the processor while a block is written back or refilled. It holds 8 blocks of 4 words. The associativity is selected at compile time.

## Interface
- No parameters; geometry is fixed: 8 blocks × 128 bits, 32-bit words.
- clk  in  1  single clock; all state updates on rising edge.
- proc_reset  in  1  asynchronous, active-high reset.
- proc_read  in  1  word read request; held by processor while proc_stall=1.
- proc_write  in  1  word write request; held while proc_stall=1.
- proc_addr  in  30  word address; [1:0] word-in-block.
- proc_wdata  in  32  write data.
- proc_rdata  out  32  read data, valid when proc_read=1 and proc_stall=0.
- proc_stall  out  1  combinational; processor must freeze.
- mem_read  out  1  block read request, held until mem_ready.
- mem_write  out  1  block write request, held until mem_ready.
- mem_addr  out  28  block address [31:4].
- mem_wdata  out  128  block being written back; word 0 in [31:0].
- mem_rdata  in  128  refill block; word 0 in [31:0].
- mem_ready  in  1  one-cycle pulse completing the current mem_read or mem_write.

## Operation
- Per block: valid, dirty, tag, 128-bit data. Per set (2-way mode): 1 LRU bit naming the least-recently-used way.
- Direct-mapped: index = proc_addr[4:2], tag = proc_addr[29:5].
- 2-way: index = proc_addr[3:2], tag = proc_addr[29:4].
- mem_addr = {tag, index}.
- States:
  - IDLE: compare.
  - WRITEBACK: mem_write=1, mem_addr/mem_wdata = victim.
  - ALLOCATE: mem_read=1, mem_addr = request block.
- IDLE, request and hit:
  - proc_stall=0.
  - Read returns word proc_addr[1:0] of the hit way.
  - Write updates that word and sets dirty at the edge.
  - LRU is set to the other way.
- IDLE, request and miss:
  - Select victim: an invalid way first (way 0 preferred), else the LRU way.
  - Victim valid and dirty → WRITEBACK; otherwise → ALLOCATE. Victim index is latched.
- WRITEBACK: on mem_ready → ALLOCATE.
- ALLOCATE: on mem_ready:
  - Store mem_rdata in the victim way; valid=1, dirty=0, tag=request tag.
  - LRU is set to the other way; → IDLE.
  - The request then hits in IDLE, and a write merges at that point.
- proc_stall = (proc_read|proc_write) & (state≠IDLE | miss).
- proc_rdata = 0 whenever proc_read=0 or there is no hit.
- proc_read and proc_write both asserted is treated as a write.
- No request in IDLE: no state change, and LRU is not updated.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, mem_read=0, mem_write=0.
  - All valid, dirty and LRU bits = 0.
  - mem_addr=0, mem_wdata=0.
  - proc_stall=0 while no request.
- Reset mid-WRITEBACK or mid-ALLOCATE abandons the transaction. mem_read/mem_write fall without waiting for the clock.
- mem_read and mem_write are decoded from registered state, are glitch-free, and are never high together.
- Hit latency: 0 stall cycles.
- Clean miss: stall = memory latency + 1 cycle (the IDLE re-compare).
- Dirty miss: stall = 2 memory latencies + 1.
- Transition gaps:
  - WRITEBACK → ALLOCATE: mem_write is low in the cycle after mem_ready; mem_read rises in that same cycle.
  - mem_read deasserts in the cycle after mem_ready.
- mem_ready while in IDLE is ignored.

## Configuration
- CACHE_2WAY_EN defined: 4 sets × 2 ways, 26-bit tags, LRU replacement.
- CACHE_2WAY_EN undefined:
  - 8 sets × 1 way, 25-bit tags; the victim is always the indexed block.
  - LRU storage is removed.
  - Port list and timing are identical.

## Test plan
- Reset, then read 0x00000004 with memory latency 3:
  - mem_read rises next cycle with mem_addr=0x0000001.
  - After mem_ready, one re-compare cycle.
  - proc_stall falls and proc_rdata = word 0 of the refill.
- Write 0xDEADBEEF to 0x00000005 (hit), then read 0x00000005:
  - Zero stall cycles; rdata = 0xDEADBEEF.
- Dirty eviction:
  - Direct-mapped: after the write above, read 0x00000025 (same index 1).
  - 2-way: fill both ways first.
  - Required response: mem_write with old block addr and mem_wdata[63:32]=0xDEADBEEF, then mem_read of the new block; mem_read/mem_write never overlap.
- 2-way LRU (CACHE_2WAY_EN):
  - Sequence: read 0x00000000, read 0x00000010, read 0x00000000, then read 0x00000020.
  - Required response: the victim is the block 0x10 way; a re-read of 0x00000000 hits.
- Assert proc_reset two cycles into ALLOCATE:
  - mem_read drops immediately; state returns to IDLE.
  - A subsequent read of the same address misses again, because valid was cleared.

Source files
------------

// File: rtl/cache_2way.sv
// cache_2way: write-back, write-allocate cache of 8 blocks x 4 words between the
// 30-bit word-addressed processor port and a 128-bit block memory.
// Hits are served combinationally. Misses stall while the victim is written back
// and/or the requested block is refilled.
// Build option: CACHE_2WAY_EN selects 4 sets x 2 ways with LRU replacement.
// Without it the cache is direct-mapped with 8 sets x 1 way.
module cache_2way (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);

`ifdef CACHE_2WAY_EN
    localparam int WAYS  = 2;
    localparam int IDX_W = 2;
    localparam int TAG_W = 26;
`else
    localparam int WAYS  = 1;
    localparam int IDX_W = 3;
    localparam int TAG_W = 25;
`endif

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t state, state_next;

    // Block storage: slot number is {set, way} in 2-way mode, the set in direct-mapped mode
    logic [7:0]       valid_bits;
    logic [7:0]       dirty_bits;
    logic [TAG_W-1:0] tag_mem  [0:7];
    logic [127:0]     data_mem [0:7];

    // Miss bookkeeping captured when the lookup misses
    logic [2:0]   victim_slot_reg;
    logic [27:0]  req_block_reg;
    logic [27:0]  mem_addr_reg;
    logic [127:0] mem_wdata_reg;

    // Request decode
    logic             req;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] req_tag;
    logic [6:0]       word_off;

    assign req      = proc_read | proc_write;
    assign idx      = proc_addr[IDX_W+1:2];
    assign req_tag  = proc_addr[29:30-TAG_W];
    assign word_off = {proc_addr[1:0], 5'b0};

    logic [WAYS-1:0] way_hit;
    logic            hit;
    logic [2:0]      hit_slot;
    logic [2:0]      victim_slot;
    logic            victim_dirty;

`ifdef CACHE_2WAY_EN
    logic [3:0] lru_bits;
    logic       hit_way;
    logic       victim_way;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_way
            localparam logic WAY_BIT = (gi == 1);
            assign way_hit[gi] = valid_bits[{idx, WAY_BIT}] &&
                                 (tag_mem[{idx, WAY_BIT}] == req_tag);
        end
    endgenerate

    assign hit_way  = way_hit[1];
    assign hit_slot = {idx, hit_way};

    // Victim choice: an empty way (way 0 first), otherwise the least-recently-used way
    always_comb begin
        victim_way = lru_bits[idx];
        if (!valid_bits[{idx, 1'b0}]) begin
            victim_way = 1'b0;
        end else if (!valid_bits[{idx, 1'b1}]) begin
            victim_way = 1'b1;
        end
    end

    assign victim_slot = {idx, victim_way};
`else
    assign way_hit[0]  = valid_bits[idx] && (tag_mem[idx] == req_tag);
    assign hit_slot    = idx;
    assign victim_slot = idx;
`endif

    assign hit          = |way_hit;
    assign victim_dirty = valid_bits[victim_slot] & dirty_bits[victim_slot];

    // Events of the current cycle
    logic lookup_hit;
    logic lookup_miss;
    logic write_hit;
    logic wb_done;
    logic fill_done;

    assign lookup_hit  = (state == IDLE) & req & hit;
    assign lookup_miss = (state == IDLE) & req & ~hit;
    assign write_hit   = lookup_hit & proc_write;
    assign wb_done     = (state == WRITEBACK) & mem_ready;
    assign fill_done   = (state == ALLOCATE) & mem_ready;

    // Processor side: hits never stall; any non-idle state or miss does
    assign proc_stall = req & ((state != IDLE) | ~hit);
    assign proc_rdata = (proc_read & hit) ? data_mem[hit_slot][word_off +: 32] : 32'd0;

    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

    // State register; reset abandons any memory transaction immediately
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (lookup_miss) begin
                    state_next = victim_dirty ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                if (mem_ready) begin
                    state_next = ALLOCATE;
                end
            end
            ALLOCATE: begin
                if (mem_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory strobes decoded purely from the registered state
    always_comb begin
        mem_read  = (state == ALLOCATE);
        mem_write = (state == WRITEBACK);
    end

    // Valid/dirty bits and the latched miss context
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            valid_bits      <= '0;
            dirty_bits      <= '0;
            victim_slot_reg <= '0;
            req_block_reg   <= '0;
            mem_addr_reg    <= '0;
            mem_wdata_reg   <= '0;
        end else begin
            if (write_hit) begin
                dirty_bits[hit_slot] <= 1'b1;
            end
            if (lookup_miss) begin
                victim_slot_reg <= victim_slot;
                req_block_reg   <= proc_addr[29:2];
                if (victim_dirty) begin
                    mem_addr_reg  <= {tag_mem[victim_slot], idx};
                    mem_wdata_reg <= data_mem[victim_slot];
                end else begin
                    mem_addr_reg  <= proc_addr[29:2];
                end
            end
            if (wb_done) begin
                mem_addr_reg <= req_block_reg;
            end
            if (fill_done) begin
                valid_bits[victim_slot_reg] <= 1'b1;
                dirty_bits[victim_slot_reg] <= 1'b0;
            end
        end
    end

`ifdef CACHE_2WAY_EN
    // LRU bit points at the way not touched most recently; idle cycles leave it alone
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            lru_bits <= '0;
        end else if (lookup_hit) begin
            lru_bits[idx] <= ~hit_way;
        end else if (fill_done) begin
            lru_bits[victim_slot_reg[2:1]] <= ~victim_slot_reg[0];
        end
    end
`endif

    // Tag and data arrays: no reset, qualified by the valid bits
    always_ff @(posedge clk) begin
        if (write_hit) begin
            data_mem[hit_slot][word_off +: 32] <= proc_wdata;
        end
        if (fill_done) begin
            data_mem[victim_slot_reg] <= mem_rdata;
            tag_mem[victim_slot_reg]  <= req_block_reg[27:IDX_W];
        end
    end

endmodule

// File: tb/tb_cache_2way.sv
// tb_cache_2way: drives cache_2way with directed and random accesses, acts as the
// block memory, and compares against a set/way model of the cache contents.
module tb_cache_2way;

`ifdef CACHE_2WAY_EN
    localparam int WAYS = 2;
    localparam int SETS = 4;
`else
    localparam int WAYS = 1;
    localparam int SETS = 8;
`endif

    logic         clk = 1'b0;
    logic         proc_reset;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    cache_2way dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int lat         = 3;

    logic [27:0]  wb_addr_q [$];
    logic [127:0] wb_data_q [$];
    logic [27:0]  rd_addr_q [$];

    // Reference model: what each set holds, plus the memory image
    bit           m_valid [SETS][WAYS];
    bit           m_dirty [SETS][WAYS];
    logic [27:0]  m_blk   [SETS][WAYS];
    logic [127:0] m_data  [SETS][WAYS];
    int           m_stamp [SETS][WAYS];
    int           tick = 0;
    logic [127:0] mmem [logic [27:0]];

    function automatic logic [31:0] pat(input logic [29:0] a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h13572468;
    endfunction

    function automatic logic [127:0] mem_block(input logic [27:0] b);
        logic [127:0] r;
        if (mmem.exists(b)) return mmem[b];
        for (int i = 0; i < 4; i++) r[32*i +: 32] = pat({b, 2'(i)});
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Block memory: answers each request after 'lat' cycles with a one-cycle mem_ready
    initial begin
        int cnt;
        cnt       = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            chk("rw_overlap", 128'(mem_read & mem_write), 128'(0));
            if (proc_reset) begin
                cnt = 0;
            end else if (mem_read || mem_write) begin
                cnt++;
                if (cnt >= lat) begin
                    cnt       = 0;
                    mem_ready = 1'b1;
                    if (mem_write) begin
                        wb_addr_q.push_back(mem_addr);
                        wb_data_q.push_back(mem_wdata);
                    end else begin
                        rd_addr_q.push_back(mem_addr);
                        mem_rdata = mem_block(mem_addr);
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            proc_read  = 1'b0;
            proc_write = 1'b0;
            #1;
            chk("idle_stall", 128'(proc_stall), 128'(0));
            chk("idle_rdata", 128'(proc_rdata), 128'(0));
        end
    endtask

    task automatic access(input bit rd, input bit wr, input logic [29:0] a,
                          input logic [31:0] wd, input int L);
        logic [27:0]  blk;
        logic [27:0]  wb_blk;
        logic [127:0] wb_exp;
        int s, hw, v, exp_stall, stalls, off;
        bit miss, dirty_ev;
        blk      = a[29:2];
        s        = int'(blk) % SETS;
        off      = 32 * int'(a[1:0]);
        hw       = -1;
        v        = -1;
        dirty_ev = 0;
        wb_blk   = '0;
        wb_exp   = '0;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_blk[s][w] == blk) hw = w;
        miss = (hw < 0);
        if (miss) begin
            for (int w = 0; w < WAYS; w++)
                if (!m_valid[s][w] && v < 0) v = w;
            if (v < 0) begin
                v = 0;
                for (int w = 0; w < WAYS; w++)
                    if (m_stamp[s][w] < m_stamp[s][v]) v = w;
            end
            dirty_ev  = m_valid[s][v] && m_dirty[s][v];
            wb_blk    = m_blk[s][v];
            wb_exp    = m_data[s][v];
            exp_stall = dirty_ev ? 2 * L + 1 : L + 1;
        end else begin
            exp_stall = 0;
        end

        lat = L;
        wb_addr_q.delete();
        wb_data_q.delete();
        rd_addr_q.delete();
        @(negedge clk);
        proc_read  = rd;
        proc_write = wr;
        proc_addr  = a;
        proc_wdata = wd;
        #1;
        stalls = 0;
        while (proc_stall && stalls < 100) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        chk("stall_cycles", 128'(stalls), 128'(exp_stall));

        if (miss) begin
            chk("wb_count", 128'(wb_addr_q.size()), 128'(dirty_ev ? 1 : 0));
            if (dirty_ev && wb_addr_q.size() > 0) begin
                chk("wb_addr", 128'(wb_addr_q[0]), 128'(wb_blk));
                chk("wb_data", wb_data_q[0], wb_exp);
            end
            if (dirty_ev) mmem[wb_blk] = wb_exp;
            chk("refill_count", 128'(rd_addr_q.size()), 128'(1));
            if (rd_addr_q.size() > 0) chk("refill_addr", 128'(rd_addr_q[0]), 128'(blk));
            m_valid[s][v] = 1;
            m_dirty[s][v] = 0;
            m_blk[s][v]   = blk;
            m_data[s][v]  = mem_block(blk);
            hw = v;
        end else begin
            chk("hit_mem_traffic", 128'(wb_addr_q.size() + rd_addr_q.size()), 128'(0));
        end

        if (rd) chk("rdata", 128'(proc_rdata), 128'(m_data[s][hw][off +: 32]));
        else    chk("rdata_noread", 128'(proc_rdata), 128'(0));

        tick++;
        m_stamp[s][hw] = tick;
        if (wr) begin
            m_data[s][hw][off +: 32] = wd;
            m_dirty[s][hw] = 1;
        end
        $display("txn rd=%0b wr=%0b addr=%08h wdata=%08h rdata=%08h stall=%0d",
                 rd, wr, a, wd, proc_rdata, stalls);
    endtask

    initial begin
        logic [29:0] ra;
        int op;
        proc_reset = 1'b1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        proc_addr  = '0;
        proc_wdata = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_read",  128'(mem_read),   128'(0));
        chk("rst_mem_write", 128'(mem_write),  128'(0));
        chk("rst_mem_addr",  128'(mem_addr),   128'(0));
        chk("rst_mem_wdata", mem_wdata,        128'(0));
        chk("rst_stall",     128'(proc_stall), 128'(0));
        chk("rst_rdata",     128'(proc_rdata), 128'(0));
        @(negedge clk);
        proc_reset = 1'b0;

        // Refill, write hit, read hit, dirty eviction of index 1
        access(1, 0, 30'h4,  32'h0,        3);
        access(0, 1, 30'h5,  32'hDEADBEEF, 2);
        access(1, 0, 30'h5,  32'h0,        2);
        access(1, 0, 30'h15, 32'h0,        2);
        access(1, 0, 30'h25, 32'h0,        3);
        // Replacement order in set 0
        access(1, 0, 30'h0,  32'h0, 2);
        access(1, 0, 30'h10, 32'h0, 2);
        access(1, 0, 30'h0,  32'h0, 2);
        access(1, 0, 30'h20, 32'h0, 2);
        access(1, 0, 30'h0,  32'h0, 2);
        idle_cycles(2);

        // Reset two cycles into a refill
        lat = 6;
        @(negedge clk);
        proc_read = 1'b1;
        proc_addr = 30'h44;
        #1;
        chk("pre_rst_miss_stall", 128'(proc_stall), 128'(1));
        @(negedge clk);
        #1;
        chk("alloc_cycle1_read", 128'(mem_read), 128'(1));
        @(negedge clk);
        #1;
        chk("alloc_cycle2_read", 128'(mem_read), 128'(1));
        #1;
        proc_reset = 1'b1;
        #1;
        chk("mid_rst_mem_read",  128'(mem_read),  128'(0));
        chk("mid_rst_mem_write", 128'(mem_write), 128'(0));
        chk("mid_rst_mem_addr",  128'(mem_addr),  128'(0));
        @(negedge clk);
        proc_read = 1'b0;
        @(negedge clk);
        proc_reset = 1'b0;
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 0;
        access(1, 0, 30'h44, 32'h0, 3);
        access(1, 0, 30'h0,  32'h0, 2);

        // Random traffic over a small address window to force conflicts
        for (int i = 0; i < 250; i++) begin
            ra = 30'($urandom_range(0, 255));
            op = int'($urandom_range(0, 3));
            access(op != 2, op >= 2, ra, $urandom, int'($urandom_range(1, 4)));
            if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 2)));
        end
        idle_cycles(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
